// File: rtl/ehxplll.sv
`timescale 1ns/1ps
// ehxplll: cycle-based behavioural model of the ECP5 EHXPLLL PLL primitive.
// CLKI is the VCO time base; each output is an integer division of it with coarse and dynamic phase.
module ehxplll #(
   parameter int    CLKI_DIV        = 1,
   parameter int    CLKFB_DIV       = 1,
   parameter string FEEDBK_PATH     = "CLKOP",
   parameter int    CLKOP_DIV       = 8,
   parameter int    CLKOS_DIV       = 8,
   parameter int    CLKOS2_DIV      = 8,
   parameter int    CLKOS3_DIV      = 8,
   parameter int    CLKOP_CPHASE    = 0,
   parameter int    CLKOS_CPHASE    = 0,
   parameter int    CLKOS2_CPHASE   = 0,
   parameter int    CLKOS3_CPHASE   = 0,
   parameter int    CLKOP_FPHASE    = 0,
   parameter int    CLKOS_FPHASE    = 0,
   parameter int    CLKOS2_FPHASE   = 0,
   parameter int    CLKOS3_FPHASE   = 0,
   parameter string CLKOP_ENABLE    = "ENABLED",
   parameter string CLKOS_ENABLE    = "DISABLED",
   parameter string CLKOS2_ENABLE   = "DISABLED",
   parameter string CLKOS3_ENABLE   = "DISABLED",
   parameter string OUTDIVIDER_MUXA = "DIVA",
   parameter string OUTDIVIDER_MUXB = "DIVB",
   parameter string OUTDIVIDER_MUXC = "DIVC",
   parameter string OUTDIVIDER_MUXD = "DIVD",
   parameter string INTFB_WAKE      = "DISABLED",
   parameter int    PLL_LOCK_MODE   = 0,
   parameter string STDBY_ENABLE    = "DISABLED",
   parameter string PLLRST_ENA      = "DISABLED",
   parameter string DPHASE_SOURCE   = "DISABLED"
) (
   input  logic CLKI,
   input  logic RST,
   input  logic STDBY,
   input  logic CLKFB,
   input  logic PHASESEL1,
   input  logic PHASESEL0,
   input  logic PHASEDIR,
   input  logic PHASESTEP,
   input  logic PHASELOADREG,
   input  logic PLLWAKESYNC,
   input  logic ENCLKOP,
   input  logic ENCLKOS,
   input  logic ENCLKOS2,
   input  logic ENCLKOS3,
   output logic CLKOP,
   output logic CLKOS,
   output logic CLKOS2,
   output logic CLKOS3,
   output logic CLKINTFB,
   output logic LOCK
);

   localparam bit stdby_en  = (STDBY_ENABLE == "ENABLED");
   localparam bit dphase_en = (DPHASE_SOURCE == "ENABLED");
   // Output index order: 0 CLKOP, 1 CLKOS, 2 CLKOS2, 3 CLKOS3
   localparam int div_tab    [4] = '{CLKOP_DIV, CLKOS_DIV, CLKOS2_DIV, CLKOS3_DIV};
   localparam int cphase_tab [4] = '{CLKOP_CPHASE, CLKOS_CPHASE, CLKOS2_CPHASE, CLKOS3_CPHASE};
   localparam logic [3:0] en_mask = {CLKOS3_ENABLE == "ENABLED", CLKOS2_ENABLE == "ENABLED",
                                     CLKOS_ENABLE == "ENABLED", CLKOP_ENABLE == "ENABLED"};
   localparam logic [6:0] ref_last = 7'(CLKI_DIV - 1);

   localparam int unused_params = CLKFB_DIV + PLL_LOCK_MODE + CLKOP_FPHASE + CLKOS_FPHASE
      + CLKOS2_FPHASE + CLKOS3_FPHASE + int'(FEEDBK_PATH != "") + int'(OUTDIVIDER_MUXA != "")
      + int'(OUTDIVIDER_MUXB != "") + int'(OUTDIVIDER_MUXC != "") + int'(OUTDIVIDER_MUXD != "")
      + int'(INTFB_WAKE != "") + int'(PLLRST_ENA != "");

   logic       unused_inputs;
   logic       stdby_hold;
   logic       step_q_reg, step_qq_reg, load_q_reg, load_qq_reg;
   logic       step_pulse, load_pulse;
   logic [1:0] sel_idx;
   logic [6:0] ref_cnt_reg;
   logic [4:0] tc_cnt_reg;
   logic       lock_reg;
   logic [3:0] clk_out;

   assign unused_inputs = ^{CLKFB, PLLWAKESYNC, ENCLKOP, ENCLKOS, ENCLKOS2, ENCLKOS3};
   assign stdby_hold    = stdby_en && STDBY;

   // Strobe edge detectors: one-cycle pulse on each rising edge of the registered strobe
   always_ff @(posedge CLKI or negedge RST) begin
      if (!RST) begin
         step_q_reg  <= 1'b0;
         step_qq_reg <= 1'b0;
         load_q_reg  <= 1'b0;
         load_qq_reg <= 1'b0;
      end else if (stdby_hold) begin
         step_q_reg  <= 1'b0;
         step_qq_reg <= 1'b0;
         load_q_reg  <= 1'b0;
         load_qq_reg <= 1'b0;
      end else begin
         step_q_reg  <= PHASESTEP;
         step_qq_reg <= step_q_reg;
         load_q_reg  <= PHASELOADREG;
         load_qq_reg <= load_q_reg;
      end
   end

   assign step_pulse = dphase_en && step_q_reg && !step_qq_reg;
   assign load_pulse = dphase_en && load_q_reg && !load_qq_reg;
   // PHASESEL 00/01/10/11 selects CLKOS/CLKOS2/CLKOS3/CLKOP, i.e. index sel+1 mod 4
   assign sel_idx    = {PHASESEL1, PHASESEL0} + 2'd1;

   always_ff @(posedge CLKI or negedge RST) begin
      if (!RST) begin
         ref_cnt_reg <= 7'd0;
         tc_cnt_reg  <= 5'd0;
         lock_reg    <= 1'b0;
      end else if (stdby_hold) begin
         ref_cnt_reg <= 7'd0;
         tc_cnt_reg  <= 5'd0;
         lock_reg    <= 1'b0;
      end else if (ref_cnt_reg == ref_last) begin
         ref_cnt_reg <= 7'd0;
         if (tc_cnt_reg == 5'd15)
            lock_reg <= 1'b1;
         if (!lock_reg)
            tc_cnt_reg <= tc_cnt_reg + 5'd1;
      end else begin
         ref_cnt_reg <= ref_cnt_reg + 7'd1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_out
         localparam int div = div_tab[gi];
         if (div >= 2) begin : g_div
            localparam int         ph       = cphase_tab[gi] % div;
            localparam logic [6:0] init_val = 7'((div - ph) % div);
            localparam logic [6:0] last     = 7'(div - 1);
            localparam logic [6:0] half     = 7'((div + 1) / 2);
            localparam logic [7:0] div8     = 8'(div);
            logic [6:0] cnt_reg, cnt_next;
            logic [7:0] cnt_plus2;
            logic       sel_hit;
            logic       out_reg;

            assign sel_hit   = (sel_idx == 2'(gi));
            assign cnt_plus2 = {1'b0, cnt_reg} + 8'd2;

            always_comb begin
               cnt_next = (cnt_reg == last) ? 7'd0 : cnt_reg + 7'd1;
               if (sel_hit && load_pulse) begin
                  cnt_next = init_val;
               end else if (sel_hit && step_pulse) begin
                  if (!PHASEDIR)
                     cnt_next = cnt_reg;
                  else
                     cnt_next = (cnt_plus2 >= div8) ? 7'(cnt_plus2 - div8) : cnt_plus2[6:0];
               end
            end

            always_ff @(posedge CLKI or negedge RST) begin
               if (!RST) begin
                  cnt_reg <= init_val;
                  out_reg <= 1'b0;
               end else if (stdby_hold) begin
                  cnt_reg <= init_val;
                  out_reg <= 1'b0;
               end else begin
                  cnt_reg <= cnt_next;
                  out_reg <= en_mask[gi] && (cnt_reg < half);
               end
            end

            assign clk_out[gi] = out_reg;
         end else begin : g_bypass
            // Divide-by-one passes CLKI straight through once the model is running
            logic running_reg;
            always_ff @(posedge CLKI or negedge RST) begin
               if (!RST)
                  running_reg <= 1'b0;
               else
                  running_reg <= !stdby_hold;
            end
            assign clk_out[gi] = en_mask[gi] && CLKI && running_reg;
         end
      end
   endgenerate

   assign CLKOP    = clk_out[0];
   assign CLKOS    = clk_out[1];
   assign CLKOS2   = clk_out[2];
   assign CLKOS3   = clk_out[3];
   assign CLKINTFB = clk_out[0];
   assign LOCK     = lock_reg;

endmodule

// File: tb/tb_ehxplll.sv
`timescale 1ns/1ps
// tb_ehxplll: directed self-checking bench for the ehxplll PLL model.
// Instance a: divided outputs, standby hold, dynamic phase; instance b: divide-by-one, no standby/dphase.
module tb_ehxplll;

   logic clki, rst, stdby, phasesel1, phasesel0, phasedir, phasestep, phaseloadreg;
   logic a_op, a_os, a_os2, a_os3, a_intfb, a_lock;
   logic b_op, b_os, b_os2, b_os3, b_intfb, b_lock;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   ehxplll #(
      .CLKI_DIV(4), .CLKOP_DIV(12), .CLKOP_CPHASE(0),
      .CLKOS_DIV(5), .CLKOS_CPHASE(2), .CLKOS_ENABLE("ENABLED"),
      .CLKOS2_DIV(3), .CLKOS2_ENABLE("DISABLED"),
      .STDBY_ENABLE("ENABLED"), .DPHASE_SOURCE("ENABLED")
   ) dut_a (
      .CLKI(clki), .RST(rst), .STDBY(stdby), .CLKFB(a_op),
      .PHASESEL1(phasesel1), .PHASESEL0(phasesel0), .PHASEDIR(phasedir),
      .PHASESTEP(phasestep), .PHASELOADREG(phaseloadreg), .PLLWAKESYNC(1'b0),
      .ENCLKOP(1'b1), .ENCLKOS(1'b1), .ENCLKOS2(1'b1), .ENCLKOS3(1'b1),
      .CLKOP(a_op), .CLKOS(a_os), .CLKOS2(a_os2), .CLKOS3(a_os3),
      .CLKINTFB(a_intfb), .LOCK(a_lock)
   );

   ehxplll #(
      .CLKI_DIV(1), .CLKOP_DIV(1), .CLKOS_DIV(3), .CLKOS_ENABLE("ENABLED"),
      .STDBY_ENABLE("DISABLED"), .DPHASE_SOURCE("DISABLED")
   ) dut_b (
      .CLKI(clki), .RST(rst), .STDBY(stdby), .CLKFB(b_op),
      .PHASESEL1(phasesel1), .PHASESEL0(phasesel0), .PHASEDIR(phasedir),
      .PHASESTEP(phasestep), .PHASELOADREG(phaseloadreg), .PLLWAKESYNC(1'b0),
      .ENCLKOP(1'b1), .ENCLKOS(1'b1), .ENCLKOS2(1'b1), .ENCLKOS3(1'b1),
      .CLKOP(b_op), .CLKOS(b_os), .CLKOS2(b_os2), .CLKOS3(b_os3),
      .CLKINTFB(b_intfb), .LOCK(b_lock)
   );

   initial begin
      clki = 1'b0;
      forever #5 clki = ~clki;
   end

   initial begin
      #50000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   // One CLKI cycle; outputs are sampled 2 ns after the rising edge (CLKI high)
   task automatic tick();
      @(posedge clki);
      #2;
      cyc++;
   endtask

   task automatic test_reset();
      rst = 1'b0; stdby = 1'b0; phasesel1 = 1'b0; phasesel0 = 1'b0;
      phasedir = 1'b0; phasestep = 1'b0; phaseloadreg = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({a_op, a_os, a_os2, a_os3, a_intfb, a_lock} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_a got=%b exp=000000", {a_op, a_os, a_os2, a_os3, a_intfb, a_lock});
         end
         n_cmp++;
         if ({b_op, b_os, b_lock} !== 3'b0) begin
            n_bad++;
            $display("FAIL reset_b got=%b exp=000", {b_op, b_os, b_lock});
         end
      end
      rst = 1'b1;
      cyc = 0;
   endtask

   task automatic test_divide();
      logic e_op, e_os, e_bos;
      for (int i = 0; i < 24; i++) begin
         tick();
         e_op  = ((cyc - 1) % 12) < 6;
         e_os  = ((cyc - 1 - 2 + 50) % 5) < 3;
         e_bos = ((cyc - 1) % 3) < 2;
         n_cmp++;
         if (a_op !== e_op) begin
            n_bad++; $display("FAIL div_clkop cyc=%0d got=%b exp=%b", cyc, a_op, e_op);
         end
         n_cmp++;
         if (a_intfb !== e_op) begin
            n_bad++; $display("FAIL div_clkintfb cyc=%0d got=%b exp=%b", cyc, a_intfb, e_op);
         end
         n_cmp++;
         if (a_os !== e_os) begin
            n_bad++; $display("FAIL div_clkos cyc=%0d got=%b exp=%b", cyc, a_os, e_os);
         end
         n_cmp++;
         if ({a_os2, a_os3} !== 2'b00) begin
            n_bad++; $display("FAIL div_disabled cyc=%0d got=%b exp=00", cyc, {a_os2, a_os3});
         end
         n_cmp++;
         if (a_lock !== 1'b0) begin
            n_bad++; $display("FAIL div_lock_early cyc=%0d got=%b exp=0", cyc, a_lock);
         end
         n_cmp++;
         if (b_op !== 1'b1) begin
            n_bad++; $display("FAIL div1_high cyc=%0d got=%b exp=1", cyc, b_op);
         end
         n_cmp++;
         if (b_os !== e_bos) begin
            n_bad++; $display("FAIL b_clkos cyc=%0d got=%b exp=%b", cyc, b_os, e_bos);
         end
         @(negedge clki);
         #1;
         n_cmp++;
         if (b_op !== 1'b0) begin
            n_bad++; $display("FAIL div1_low cyc=%0d got=%b exp=0", cyc, b_op);
         end
      end
   endtask

   task automatic test_lock();
      while (cyc < 100) begin
         tick();
         n_cmp++;
         if (a_lock !== (cyc >= 64)) begin
            n_bad++; $display("FAIL lock_a cyc=%0d got=%b exp=%b", cyc, a_lock, cyc >= 64);
         end
         n_cmp++;
         if (b_lock !== (cyc >= 16)) begin
            n_bad++; $display("FAIL lock_b cyc=%0d got=%b exp=%b", cyc, b_lock, cyc >= 16);
         end
      end
   endtask

   task automatic test_reset_mid();
      n_cmp++;
      if ({a_op, a_os, a_lock, b_op, b_os, b_lock} !== 6'b111111) begin
         n_bad++;
         $display("FAIL pre_reset got=%b exp=111111", {a_op, a_os, a_lock, b_op, b_os, b_lock});
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({a_op, a_os, a_lock, a_intfb, b_op, b_os, b_lock} !== 7'b0) begin
         n_bad++;
         $display("FAIL async_reset got=%b exp=0000000",
                  {a_op, a_os, a_lock, a_intfb, b_op, b_os, b_lock});
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if ({a_op, a_os, a_lock, b_op, b_lock} !== 5'b0) begin
            n_bad++;
            $display("FAIL held_reset got=%b exp=00000", {a_op, a_os, a_lock, b_op, b_lock});
         end
      end
      rst = 1'b1;
      cyc = 0;
   endtask

   task automatic test_relock();
      logic e_op;
      for (int i = 0; i < 70; i++) begin
         tick();
         e_op = ((cyc - 1) % 12) < 6;
         n_cmp++;
         if (a_op !== e_op) begin
            n_bad++; $display("FAIL relock_clkop cyc=%0d got=%b exp=%b", cyc, a_op, e_op);
         end
         n_cmp++;
         if (a_lock !== (cyc >= 64)) begin
            n_bad++; $display("FAIL relock_a cyc=%0d got=%b exp=%b", cyc, a_lock, cyc >= 64);
         end
         n_cmp++;
         if (b_lock !== (cyc >= 16)) begin
            n_bad++; $display("FAIL relock_b cyc=%0d got=%b exp=%b", cyc, b_lock, cyc >= 16);
         end
      end
   endtask

   // A strobe raised after cycle k is registered at edge k+1 and acts at edge k+2,
   // so the new CLKOS lag is visible from cycle k+3 onward.
   task automatic test_phase_step();
      int   lag     = 2;
      int   lag_new = 2;
      int   chg     = -1;
      logic e_op, e_os, e_bos;
      phasesel1 = 1'b0;
      phasesel0 = 1'b0;
      while (cyc < 121) begin
         case (cyc)
            70:         begin phasedir = 1'b0; phasestep = 1'b1; chg = 73; lag_new = 3; end
            73, 86, 99: phasestep = 1'b0;
            83:         begin phasedir = 1'b1; phasestep = 1'b1; chg = 86; lag_new = 2; end
            96:         begin phasestep = 1'b1; chg = 99; lag_new = 1; end
            108:        begin phaseloadreg = 1'b1; chg = 111; lag_new = 2; end
            111:        phaseloadreg = 1'b0;
            default:    ;
         endcase
         tick();
         if (cyc == chg)
            lag = lag_new;
         e_op  = ((cyc - 1) % 12) < 6;
         e_os  = ((cyc - 1 - lag + 50) % 5) < 3;
         e_bos = ((cyc - 1) % 3) < 2;
         n_cmp++;
         if (a_os !== e_os) begin
            n_bad++; $display("FAIL phase_clkos cyc=%0d lag=%0d got=%b exp=%b", cyc, lag, a_os, e_os);
         end
         n_cmp++;
         if (a_op !== e_op) begin
            n_bad++; $display("FAIL phase_clkop cyc=%0d got=%b exp=%b", cyc, a_op, e_op);
         end
         n_cmp++;
         if (b_os !== e_bos) begin
            n_bad++; $display("FAIL phase_ignored_b cyc=%0d got=%b exp=%b", cyc, b_os, e_bos);
         end
      end
   endtask

   task automatic test_standby();
      int   org;
      int   j;
      logic e_op, e_os, e_bos;
      stdby = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         e_bos = ((cyc - 1) % 3) < 2;
         n_cmp++;
         if ({a_op, a_os, a_intfb, a_lock} !== 4'b0) begin
            n_bad++;
            $display("FAIL stdby_a cyc=%0d got=%b exp=0000", cyc, {a_op, a_os, a_intfb, a_lock});
         end
         n_cmp++;
         if ({b_op, b_lock, b_os} !== {2'b11, e_bos}) begin
            n_bad++;
            $display("FAIL stdby_b cyc=%0d got=%b exp=%b", cyc, {b_op, b_lock, b_os}, {2'b11, e_bos});
         end
      end
      stdby = 1'b0;
      org = cyc;
      for (int i = 0; i < 70; i++) begin
         tick();
         j    = cyc - org;
         e_op = ((j - 1) % 12) < 6;
         e_os = ((j - 1 - 2 + 50) % 5) < 3;
         n_cmp++;
         if (a_op !== e_op) begin
            n_bad++; $display("FAIL wake_clkop j=%0d got=%b exp=%b", j, a_op, e_op);
         end
         n_cmp++;
         if (a_os !== e_os) begin
            n_bad++; $display("FAIL wake_clkos j=%0d got=%b exp=%b", j, a_os, e_os);
         end
         n_cmp++;
         if (a_lock !== (j >= 64)) begin
            n_bad++; $display("FAIL wake_lock j=%0d got=%b exp=%b", j, a_lock, j >= 64);
         end
      end
   endtask

   initial begin
      test_reset();
      test_divide();
      test_lock();
      test_reset_mid();
      test_relock();
      test_phase_step();
      test_standby();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
